// File: rtl/complex_mix_engine_if.sv
// Start/busy/done job handshake and lane buses for complex_mix_engine.
interface complex_mix_engine_if #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 8,
    parameter int ROUNDS = 12
);
    localparam int CW = $clog2(ROUNDS + 1);

    logic                     start;
    logic [LANES*WIDTH-1:0]   seed_in;
    logic                     busy;
    logic                     done;
    logic [LANES*WIDTH-1:0]   result;
    logic [CW-1:0]            round_cnt;

    modport master (
        output start,
        output seed_in,
        input  busy,
        input  done,
        input  result,
        input  round_cnt
    );

    modport slave (
        input  start,
        input  seed_in,
        output busy,
        output done,
        output result,
        output round_cnt
    );
endinterface

// File: rtl/complex_mix_engine.sv
// Multi-cycle lane mixer: LOAD, ROUNDS single-cycle rounds, FIN.
// Optional MIX_FINAL_MUL_EN adds a POST multiply state before FIN.
module complex_mix_engine #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 8,
    parameter int ROUNDS = 12,
    parameter int SHL    = 16,
    parameter int SHRA   = 17,
    parameter int SHRB   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    complex_mix_engine_if.slave  bus
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
`ifdef MIX_FINAL_MUL_EN
        POST = 3'd3,
`endif
        FIN  = 3'd4
    } state_t;

    state_t         state_q;
    vec_t           lanes_q;
    vec_t           result_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    vec_t           round_d;
    vec_t           post_d;

    function automatic logic [IW-1:0] idx(input int i, input int k);
        return IW'((i + k) % LANES);
    endfunction

    // Lanes update in order so later lanes see earlier results.
    function automatic vec_t mix_round(input vec_t v);
        vec_t l;
        l = v;
        for (int i = 0; i < LANES; i++) begin
            l[i] = l[i] + l[idx(i, 1)] - l[idx(i, LANES - 3)];
        end
        for (int i = 0; i < LANES; i++) begin
            l[i] = l[i] ^ (l[idx(i, 3)] << SHL);
        end
        for (int i = 0; i < LANES; i++) begin
            l[i] = l[i] - (l[idx(i, 2)] >> SHRA)
                        + (l[idx(i, 4)] >> SHRB);
        end
        return l;
    endfunction

    always_comb begin
        round_d = mix_round(lanes_q);
        post_d  = lanes_q;
        for (int i = 0; i < LANES; i++) begin
            post_d[i] = lanes_q[i] * WIDTH'(2 * i + 3)
                      + WIDTH'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lanes_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    lanes_q <= bus.seed_in;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    lanes_q <= round_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ROUNDS - 1)) begin
`ifdef MIX_FINAL_MUL_EN
                        state_q <= POST;
`else
                        state_q <= FIN;
`endif
                    end
                end
`ifdef MIX_FINAL_MUL_EN
                POST: begin
                    lanes_q <= post_d;
                    state_q <= FIN;
                end
`endif
                FIN: begin
                    result_q <= lanes_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.round_cnt = cnt_q;

endmodule

// File: tb/tb_complex_mix_engine.sv
// Directed self-checking bench for complex_mix_engine at default parameters.
module tb_complex_mix_engine;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int R  = 12;
`ifdef MIX_FINAL_MUL_EN
    localparam int LAT = R + 3;
`else
    localparam int LAT = R + 2;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    complex_mix_engine_if #(.WIDTH(W), .LANES(N), .ROUNDS(R)) bus ();

    complex_mix_engine #(
        .WIDTH(W), .LANES(N), .ROUNDS(R),
        .SHL(16), .SHRA(17), .SHRB(12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: blocking 3-stage round applied R times.
    function automatic logic [255:0] model(input logic [255:0] seed);
        bit [31:0] L [8];
        logic [255:0] r;
        for (int i = 0; i < 8; i++) L[i] = seed[i*32 +: 32];
        for (int k = 0; k < R; k++) begin
            for (int i = 0; i < 8; i++)
                L[i] = L[i] + L[(i+1)%8] - L[(i+5)%8];
            for (int i = 0; i < 8; i++)
                L[i] = L[i] ^ (L[(i+3)%8] << 16);
            for (int i = 0; i < 8; i++)
                L[i] = L[i] - (L[(i+2)%8] >> 17)
                            + (L[(i+4)%8] >> 12);
        end
`ifdef MIX_FINAL_MUL_EN
        for (int i = 0; i < 8; i++)
            L[i] = L[i] * (2*i + 3) + i;
`endif
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = L[i];
        return r;
    endfunction

    task automatic run_job(input logic [255:0] seed, output int lat);
        @(negedge clk);
        bus.seed_in = seed;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
    endtask

    logic [255:0] seed_z, seed_i, seed_h, exp_v;
    int lat, ndone, t1, t2, cyc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.seed_in = '0;
        seed_z = '0;
        for (int i = 0; i < 8; i++) begin
            seed_i[i*32 +: 32] = 32'(i);
            seed_h[i*32 +: 32] = 32'h9E3779B9 * 32'(i + 1);
        end

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cnt", bus.round_cnt, 0);
        rst_n = 1'b1;

        // Zero seed: fixed point, timing of done/busy.
        exp_v = '0;
`ifdef MIX_FINAL_MUL_EN
        for (int i = 0; i < 8; i++) exp_v[i*32 +: 32] = 32'(i);
`endif
        run_job(seed_z, lat);
        check("zero_lat", lat, LAT);
        check("zero_result", bus.result, exp_v);
        check("zero_busy_at_done", bus.busy, 0);
        check("zero_cnt", bus.round_cnt, R);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);

        // Progress counters mid-job.
        bus.seed_in = seed_i;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("load_busy", bus.busy, 1);
        @(negedge clk);
        check("load_cnt", bus.round_cnt, 0);
        repeat (3) @(negedge clk);
        check("run_cnt3", bus.round_cnt, 3);
        check("run_busy", bus.busy, 1);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("seqi_result", bus.result, model(seed_i));

        run_job(seed_h, lat);
        check("hash_lat", lat, LAT);
        check("hash_result", bus.result, model(seed_h));
        repeat (5) @(negedge clk);
        check("result_hold", bus.result, model(seed_h));

        // start held high: back-to-back jobs, one done each.
        bus.seed_in = seed_i;
        bus.start = 1'b1;
        ndone = 0;
        t1 = 0;
        t2 = 0;
        for (cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (ndone == 1) t1 = cyc;
                if (ndone == 2) begin
                    t2 = cyc;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("held_two_done", ndone, 2);
        check("held_period", t2 - t1, LAT + 1);
        check("held_result", bus.result, model(seed_i));
        repeat (LAT + 4) @(negedge clk);
        check("held_no_third", bus.busy, 0);

        // Reset mid-job.
        @(negedge clk);
        bus.seed_in = seed_h;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.round_cnt != 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round5", bus.round_cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_cnt", bus.round_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_job(seed_h, lat);
        check("after_abort_lat", lat, LAT);
        check("after_abort_result", bus.result, model(seed_h));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
